paillier_out_buffer: RTL and testbench

PAILLIER_OUT_BUFFER -- requirements
Module: paillier_out_buffer

---
 rtl/paillier_out_buffer.sv | 175 +++++++++++++++++
 tb/tb_paillier_out_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paillier_out_buffer.sv
// paillier_out_buffer
// Ping-pong output buffer between the Paillier encryption core and a
// ready/valid consumer. The core streams K-bit words with no backpressure;
// every N words form one result frame. Frames are captured into one of two
// banks and drained in arrival order. A frame that arrives while both banks
// still hold undrained frames is dropped whole and the sticky ovf flag is set.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   enc_out_data    K-bit word from the core, low word of a frame first
//   enc_out_valid   word strobe from the core
//   out_data        registered drain word
//   out_valid       drain word valid
//   out_last        last word of a frame (qualified by out_valid)
//   out_ready       downstream accept
//   ovf             sticky overflow (a frame was dropped)
//   clr_ovf         synchronous clear of ovf (a same-edge drop wins)
//   bank_full       per-bank full flags, bit b = bank b
module paillier_out_buffer #(
    parameter int K = 128,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [K-1:0] enc_out_data,
    input  logic         enc_out_valid,
    output logic [K-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         ovf,
    input  logic         clr_ovf,
    output logic [1:0]   bank_full
);

    localparam int            W    = $clog2(N);
    localparam logic [W-1:0]  LAST = W'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [W-1:0]   rd_cnt_q, rd_cnt_d;
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic           acc_q, acc_d;          // current incoming frame is being kept
    logic [1:0]     full_q, full_d;
    logic [1:0]     full_dly_q;            // full flags one cycle late
    logic           ovf_q, ovf_d;
    logic           out_valid_q, out_valid_d;
    logic [K-1:0]   out_data_q, out_data_d;

    logic [K-1:0]   mem_q [2][N];

    logic           hs;
    logic           drain_last;
    logic           acc_now;
    logic           wr_en;
    logic           drop;
    logic [W-1:0]   rd_nxt;

    always_comb begin
        hs         = (state_q == SEND) && out_valid_q && out_ready;
        drain_last = hs && (rd_cnt_q == LAST);
        rd_nxt     = rd_cnt_q + 1'b1;

        // The keep/drop decision is taken at word 0 and held for the frame.
        // A bank being released by the final drain handshake on this same
        // edge counts as free.
        if (wr_cnt_q == '0)
            acc_now = !full_q[wr_bank_q] || (drain_last && (rd_bank_q == wr_bank_q));
        else
            acc_now = acc_q;

        wr_en = enc_out_valid && acc_now;
        drop  = enc_out_valid && !acc_now && (wr_cnt_q == '0);

        wr_cnt_d    = wr_cnt_q;
        acc_d       = acc_q;
        wr_bank_d   = wr_bank_q;
        full_d      = full_q;
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (enc_out_valid) begin
            wr_cnt_d = wr_cnt_q + 1'b1;   // N is a power of two: wraps N-1 -> 0
            acc_d    = acc_now;
        end

        // Drop beats clear when both happen on the same edge.
        if (drop)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;

        if (drain_last)
            full_d[rd_bank_q] = 1'b0;
        if (wr_en && (wr_cnt_q == LAST)) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end

        case (state_q)
            IDLE: begin
                // Wait for the delayed copy too, so a freshly completed frame
                // starts draining on the second edge after its last word.
                if (full_q[rd_bank_q] && full_dly_q[rd_bank_q]) begin
                    state_d     = SEND;
                    out_data_d  = mem_q[rd_bank_q][0];
                    out_valid_d = 1'b1;
                    rd_cnt_d    = '0;
                end
            end
            SEND: begin
                if (hs) begin
                    if (rd_cnt_q != LAST) begin
                        out_data_d = mem_q[rd_bank_q][rd_nxt];
                        rd_cnt_d   = rd_nxt;
                    end else begin
                        out_valid_d = 1'b0;
                        rd_bank_d   = ~rd_bank_q;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            acc_q       <= 1'b0;
            full_q      <= 2'b00;
            full_dly_q  <= 2'b00;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            acc_q       <= acc_d;
            full_q      <= full_d;
            full_dly_q  <= full_q;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Frame storage carries no reset; the full flags say what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_bank_q][wr_cnt_q] <= enc_out_data;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = (state_q == SEND) && (rd_cnt_q == LAST);
    assign ovf       = ovf_q;
    assign bank_full = full_q;

endmodule

// File: tb/tb_paillier_out_buffer.sv
module tb_paillier_out_buffer;
    localparam int K = 128;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [K-1:0] enc_out_data = '0;
    logic         enc_out_valid = 1'b0;
    logic [K-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready = 1'b0;
    logic         ovf;
    logic         clr_ovf = 1'b0;
    logic [1:0]   bank_full;

    int checks = 0;
    int passes = 0;

    paillier_out_buffer #(.K(K), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .enc_out_data(enc_out_data), .enc_out_valid(enc_out_valid),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .ovf(ovf), .clr_ovf(clr_ovf),
        .bank_full(bank_full)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Frames are whole units: a buffer holds at most two complete frames.
    // A frame is kept if fewer than two are stored when its first word
    // arrives, or if a stored frame finishes draining on that same edge.
    logic [K-1:0] exp_q[$];
    logic [K-1:0] cur[$];
    int  pend = 0, wcnt = 0, rd_idx = 0;
    bit  cur_acc = 1'b0, m_ovf = 1'b0;
    bit  m_hs, m_dl, m_drop, m_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete(); cur.delete();
            pend = 0; wcnt = 0; rd_idx = 0; cur_acc = 1'b0; m_ovf = 1'b0;
        end else begin
            checks++;
            if (ovf !== m_ovf) $display("FAIL ovf_track: got %0b want %0b", ovf, m_ovf);
            else passes++;
            checks++;
            if ($countones(bank_full) != pend)
                $display("FAIL full_count: got %b want %0d full banks", bank_full, pend);
            else passes++;

            m_hs = out_valid && out_ready;
            m_dl = m_hs && (rd_idx == N - 1);
            m_acc = cur_acc;
            if (enc_out_valid && wcnt == 0) m_acc = (pend < 2) || m_dl;

            if (m_hs) begin
                checks++;
                if (exp_q.size() == 0)
                    $display("FAIL drain_word: got unexpected %0h want nothing", out_data);
                else if (out_data !== exp_q[0] || out_last !== (rd_idx == N - 1))
                    $display("FAIL drain_word: got %0h last %0b want %0h last %0b",
                             out_data, out_last, exp_q[0], rd_idx == N - 1);
                else passes++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                rd_idx = (rd_idx + 1) % N;
                if (rd_idx == 0) pend--;
            end

            m_drop = 1'b0;
            if (enc_out_valid) begin
                if (wcnt == 0) begin
                    cur_acc = m_acc;
                    cur.delete();
                    m_drop = !m_acc;
                end
                if (cur_acc) cur.push_back(enc_out_data);
                if (wcnt == N - 1 && cur_acc) begin
                    foreach (cur[i]) exp_q.push_back(cur[i]);
                    pend++;
                end
                wcnt = (wcnt + 1) % N;
            end
            if (m_drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_word(input logic [K-1:0] d);
        enc_out_valid = 1'b1;
        enc_out_data  = d;
        @(posedge clk); #1;
        enc_out_valid = 1'b0;
    endtask

    task automatic send_rand_frame();
        for (int i = 0; i < N; i++) drive_word({$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic wait_drain();
        int n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 200) $display("FAIL drain_timeout: got %0d words left want 0", exp_q.size());
        else passes++;
    endtask

    task automatic pulse_clr();
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passes++;
        checks++; if (out_last !== 1'b0) $display("FAIL rst_last: got %b want 0", out_last); else passes++;
        checks++; if (out_data !== '0) $display("FAIL rst_data: got %0h want 0", out_data); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf); else passes++;
        checks++; if (bank_full !== 2'b00) $display("FAIL rst_full: got %b want 00", bank_full); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        logic [K-1:0] w [4];
        w[0] = 128'h11; w[1] = 128'h22; w[2] = 128'h33; w[3] = 128'h44;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) drive_word(w[i]);
        checks++; if (out_valid !== 1'b0) $display("FAIL lat_e0: got %b want 0", out_valid); else passes++;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL lat_e1: got %b want 0", out_valid); else passes++;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== w[k] || out_last !== (k == N - 1))
                $display("FAIL single_word%0d: got v%b %0h l%b want v1 %0h l%0b",
                         k, out_valid, out_data, out_last, w[k], k == N - 1);
            else passes++;
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b0) $display("FAIL single_end: got %b want 0", out_valid); else passes++;
        checks++; if (bank_full !== 2'b00) $display("FAIL single_full: got %b want 00", bank_full); else passes++;
    endtask

    task automatic test_backpressure();
        bit held_v = 1'b0;
        logic [K-1:0] held = '0;
        out_ready = 1'b0;
        send_rand_frame();
        for (int i = 0; i < 20; i++) begin
            if (held_v) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held)
                    $display("FAIL bp_hold: got v%b %0h want v1 %0h", out_valid, out_data, held);
                else passes++;
            end
            out_ready = (i % 2 == 0);
            @(negedge clk);
            held_v = out_valid && !out_ready;
            held   = out_data;
            @(posedge clk); #1;
        end
        wait_drain();
    endtask

    task automatic test_overflow();
        logic [11:0] vbits, vexp;
        out_ready = 1'b0;
        send_rand_frame();
        send_rand_frame();
        checks++; if (bank_full !== 2'b11) $display("FAIL ovf_full: got %b want 11", bank_full); else passes++;
        drive_word({$urandom, $urandom, $urandom, $urandom});
        checks++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf); else passes++;
        for (int i = 1; i < N; i++) drive_word({$urandom, $urandom, $urandom, $urandom});
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vbits[i] = out_valid;
        end
        vexp = 12'b0001_1110_1111;
        checks++;
        if (vbits !== vexp) $display("FAIL ovf_idle_gap: got %b want %b", vbits, vexp);
        else passes++;
        wait_drain();
        pulse_clr();
        checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf); else passes++;
    endtask

    task automatic test_free_same_edge();
        out_ready = 1'b0;
        send_rand_frame();
        send_rand_frame();
        checks++; if (bank_full !== 2'b11) $display("FAIL free_full: got %b want 11", bank_full); else passes++;
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        send_rand_frame();
        checks++; if (ovf !== 1'b0) $display("FAIL free_ovf: got %b want 0", ovf); else passes++;
        wait_drain();
        checks++; if (bank_full !== 2'b00) $display("FAIL free_end: got %b want 00", bank_full); else passes++;
    endtask

    task automatic test_ovf_clear();
        out_ready = 1'b0;
        send_rand_frame();
        send_rand_frame();
        send_rand_frame();
        checks++; if (ovf !== 1'b1) $display("FAIL clr_pre: got %b want 1", ovf); else passes++;
        pulse_clr();
        checks++; if (ovf !== 1'b0) $display("FAIL clr_one: got %b want 0", ovf); else passes++;
        clr_ovf = 1'b1;
        drive_word({$urandom, $urandom, $urandom, $urandom});
        clr_ovf = 1'b0;
        checks++; if (ovf !== 1'b1) $display("FAIL clr_vs_drop: got %b want 1", ovf); else passes++;
        for (int i = 1; i < N; i++) drive_word({$urandom, $urandom, $urandom, $urandom});
        wait_drain();
        pulse_clr();
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b0;
        send_rand_frame();
        for (int i = 0; i < 3; i++) drive_word({$urandom, $urandom, $urandom, $urandom});
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || ovf !== 1'b0 || bank_full !== 2'b00)
            $display("FAIL midrst_out: got v%b l%b d%0h o%b f%b want all 0",
                     out_valid, out_last, out_data, ovf, bank_full);
        else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_rand_frame();
        wait_drain();
        checks++; if (bank_full !== 2'b00) $display("FAIL midrst_full: got %b want 00", bank_full); else passes++;
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int f = 0; f < 12; f++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    send_rand_frame();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        wait_drain();
        checks++; if (bank_full !== 2'b00) $display("FAIL rand_end: got %b want 00", bank_full); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_free_same_edge();
        test_ovf_clear();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
